// File: rtl/ram_master_pkg.sv
// Shared types and default geometry for the RAM port master and its init sequencer.
package ram_master_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 6;
    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned RAM_DEPTH          = 2 ** DEFAULT_ADDR_WIDTH;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_ISSUE,
        RD_CAPTURE,
        RESP
    } state_t;

endpackage

// File: rtl/ram_init_sequencer.sv
// Post-reset sweep that writes zero to every RAM word, one address per cycle.
// Only instantiated when RAM_MASTER_INIT_EN is defined.
module ram_init_sequencer
    import ram_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_enable,
    output logic                  done,
    output logic                  last_c
);

    logic [ADDR_WIDTH-1:0] count;

    // Address counter runs until the top word has been written.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            done  <= 1'b0;
        end else if (!done) begin
            count <= count + ADDR_WIDTH'(1);
            if (last_c) begin
                done <= 1'b1;
            end
        end
    end

    assign last_c       = !done && (&count);
    assign address      = count;
    assign write_data   = '0;
    // Gated by reset_n so no write is presented while the block is held in reset.
    assign write_enable = !done && reset_n;

endmodule

// File: rtl/ram_port_master.sv
// Valid/ready request front end for one port of the synchronous dual-port RAM.
// Optional zero-fill after reset when RAM_MASTER_INIT_EN is defined.
module ram_port_master
    import ram_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic                  ram_write_enable,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    output logic                  init_done
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  accept;

`ifdef RAM_MASTER_INIT_EN
    logic [ADDR_WIDTH-1:0] seq_address;
    logic [DATA_WIDTH-1:0] seq_write_data;
    logic                  seq_write_enable;
    logic                  seq_done;
    logic                  seq_last_c;

    ram_init_sequencer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_init (
        .clock        (clock),
        .reset_n      (reset_n),
        .address      (seq_address),
        .write_data   (seq_write_data),
        .write_enable (seq_write_enable),
        .done         (seq_done),
        .last_c       (seq_last_c)
    );

    // Sequencer owns the RAM port until the sweep completes.
    assign ram_address      = seq_done ? addr_q  : seq_address;
    assign ram_write_data   = seq_done ? wdata_q : seq_write_data;
    assign ram_write_enable = seq_done ? we_q    : seq_write_enable;
    assign init_done        = seq_done;
`else
    assign ram_address      = addr_q;
    assign ram_write_data   = wdata_q;
    assign ram_write_enable = we_q;
    assign init_done        = reset_n;
`endif

    assign req_ready  = (state_q == IDLE) && reset_n;
    assign accept     = req_valid && req_ready;
    assign resp_valid = rvalid_q;
    assign resp_data  = rdata_q;

    // State and registered port/response values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
`ifdef RAM_MASTER_INIT_EN
            state_q <= INIT;
`else
            state_q <= IDLE;
`endif
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next state; write enable defaults low so it pulses for exactly one cycle.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;

        case (state_q)
            INIT: begin
`ifdef RAM_MASTER_INIT_EN
                if (seq_last_c) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            IDLE: begin
                if (accept) begin
                    addr_d = req_address;
                    if (req_write) begin
                        wdata_d = req_data;
                        we_d    = 1'b1;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                state_d = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                rdata_d  = ram_read_data;
                rvalid_d = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/ram_port_master.md
# ram_port_master

Request/response initiator that drives one port of the team's 64×8 synchronous dual-port RAM; the RAM itself is the responder. It turns a valid/ready request stream into correctly timed RAM port signals and returns read data over a valid/ready response channel. It hides the RAM's one-cycle read latency and its "no read while writing" rule. One instance sits in front of each RAM port used by a client.

## Interface
- ADDR_WIDTH, 6, RAM address width (depth = 2**ADDR_WIDTH)
- DATA_WIDTH, 8, RAM word width
- clock  in  1  rising-edge clock shared with the RAM
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_address  in  ADDR_WIDTH  target word
- req_data  in  DATA_WIDTH  write data; ignored for reads
- resp_valid  out  1  read data available
- resp_ready  in  1  consumer takes resp_data
- resp_data  out  DATA_WIDTH  read result
- ram_address  out  ADDR_WIDTH  to RAM address port
- ram_write_data  out  DATA_WIDTH  to RAM write data port
- ram_write_enable  out  1  to RAM write enable port
- ram_read_data  in  DATA_WIDTH  from RAM read data port
- init_done  out  1  high once the block can accept requests

## Operation
- States: INIT (macro only), IDLE, RD_ISSUE, RD_CAPTURE, RESP.
- req_ready = (state == IDLE) && reset_n. This is combinational from the state register.
- Write accepted in IDLE:
  - Register ram_address = req_address, ram_write_data = req_data, ram_write_enable = 1 for exactly one cycle.
  - State stays IDLE, so back-to-back writes run at one per cycle.
- Read accepted in IDLE:
  - Register ram_address = req_address and ram_write_enable = 0.
  - IDLE → RD_ISSUE → RD_CAPTURE. In RD_CAPTURE, resp_data <= ram_read_data and resp_valid <= 1, then go to RESP.
- RESP:
  - resp_valid and resp_data hold stable until resp_valid && resp_ready at an edge.
  - On that edge: resp_valid <= 0, go to IDLE.
  - No new request is accepted in the handshake cycle itself.
- Any cycle without an accepted write drives ram_write_enable = 0. ram_address and ram_write_data hold their last values.
- Only one read is outstanding at a time. Reads are never posted behind an unconsumed response.

## Timing
- Reset values:
  - state = INIT if the macro is defined, else IDLE.
  - resp_valid = 0, resp_data = 0, ram_address = 0, ram_write_data = 0, ram_write_enable = 0.
  - req_ready = 0 while reset_n is low.
  - init_done = 0 with the macro; without it, init_done = 1 as soon as reset_n is high.
- Write: accepted at edge E0. The RAM writes at E1.
- Read: accepted at E0, RAM captures at E1, resp_valid is high after E2. Minimum request-to-next-request spacing for reads is 4 cycles (with resp_ready held high).
- Read-after-write to the same address, issued back-to-back, returns the new data.
- req_valid may drop without acceptance. The block does not rely on request stability except at the accepting edge.
- Reset asserted mid-read or while in RESP aborts immediately: the response is dropped and resp_valid = 0 asynchronously.
- Address arithmetic wraps modulo 2**ADDR_WIDTH. No out-of-range condition exists.

## Configuration
- RAM_MASTER_INIT_EN defined:
  - After reset the block is in INIT and writes 0 to addresses 0 through 2**ADDR_WIDTH−1, one per cycle, with ram_write_enable = 1 (64 cycles at defaults).
  - It then enters IDLE and sets init_done = 1.
  - req_ready = 0 throughout INIT. Reset during INIT restarts the sweep at address 0.
- Not defined: there is no INIT state, init_done is constant 1 out of reset, and RAM contents are unspecified.

## Structure
- Package ram_master_pkg:
  - State enum (INIT, IDLE, RD_ISSUE, RD_CAPTURE, RESP).
  - Default ADDR_WIDTH/DATA_WIDTH constants.
  - RAM_DEPTH = 2**ADDR_WIDTH.
- Optional sub-module ram_init_sequencer, compiled only under RAM_MASTER_INIT_EN:
  - Holds the address counter and done flag.
  - Takes over the RAM port outputs while its done flag is low.

## Test plan
- Write 8'd9 to address 9, then read address 9 with resp_ready = 1 → resp_valid rises 2 cycles after acceptance with resp_data = 8'd9, and resp_valid is held for exactly 1 cycle.
- Three back-to-back writes (addresses 1/2/3, data 8'hA1/8'hA2/8'hA3) → req_ready is high every cycle, ram_write_enable is high 3 consecutive cycles, and reads return the matching data.
- Read address 3 with resp_ready = 0 for 5 cycles → resp_valid and resp_data = 8'hA3 stay stable and req_ready stays 0; response completes when resp_ready rises.
- Assert reset_n low while in RD_CAPTURE → resp_valid = 0 immediately and ram_write_enable = 0; after release, a read of address 27 returns correctly.
- With RAM_MASTER_INIT_EN: release reset → init_done stays low for 64 cycles, then a read of address 63 returns 8'd0.
- Write to address 6'd63, then address 6'd0 → both retained with no aliasing.
